// File: rtl/ad5543_pkg.sv
// Shared types and constants for the AD5543 serial link receiver.
package ad5543_pkg;

  typedef enum logic [1:0] {
    WAIT_IDLE,
    IDLE,
    SHIFT
  } rx_state_t;

  localparam int AD5543_DW = 16;

endpackage

// File: rtl/ad5543_serial_rx_sync_edge.sv
// Two-flop synchroniser followed by a history flop, giving the synced level
// plus single-cycle rise and fall strobes for one asynchronous input pin.
module sync_edge #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic stage1;
  logic stage2;
  logic hist;

  // Resynchronise the pin and keep one cycle of history for edge detection.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stage1 <= RST_VAL;
      stage2 <= RST_VAL;
      hist   <= RST_VAL;
    end else begin
      stage1 <= din;
      stage2 <= stage1;
      hist   <= stage2;
    end
  end

  assign level = stage2;
  assign rise  = stage2 & ~hist;
  assign fall  = ~stage2 & hist;

endmodule

// File: rtl/ad5543_serial_rx.sv
// Oversampling receiver for the AD5543 3-wire DAC link. Deserialises
// MSB-first frames and hands complete words to an AXI-stream master port,
// flagging frames of the wrong length and words lost to output overruns.
module ad5543_serial_rx
  import ad5543_pkg::*;
#(
  parameter int DW = AD5543_DW,
  parameter int CW = 16
) (
  input  logic          aclk,
  input  logic          areset,
  input  logic          sclk,
  input  logic          sdi,
  input  logic          cs_n,
  output logic          m_axis_tvalid,
  input  logic          m_axis_tready,
  output logic [DW-1:0] m_axis_tdata,
  output logic          frame_err,
  output logic          overflow,
  output logic [CW-1:0] err_cnt,
  output logic [CW-1:0] ovf_cnt
);

  localparam int             CNTW     = $clog2(DW + 2);
  localparam logic [CNTW-1:0] CNT_FULL = CNTW'(DW);
  localparam logic [CNTW-1:0] CNT_MAX  = CNTW'(DW + 1);

  logic sclk_level, sclk_rise, sclk_fall;
  logic sdi_level, sdi_rise, sdi_fall;
  logic cs_level, cs_rise, cs_fall;
  logic unused_edges;

  rx_state_t       state, state_next;
  logic [1:0]      settle_cnt;
  logic            settled;
  logic            clear_frame, close_frame;
  logic            shift_take;
  logic [DW-1:0]   shift_reg, shift_next;
  logic [CNTW-1:0] bit_cnt, count_next;
  logic            good_word, bad_word, ovf_hit;

  sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
    .clk(aclk), .rst(areset), .din(sclk),
    .level(sclk_level), .rise(sclk_rise), .fall(sclk_fall)
  );

  sync_edge #(.RST_VAL(1'b0)) u_sync_sdi (
    .clk(aclk), .rst(areset), .din(sdi),
    .level(sdi_level), .rise(sdi_rise), .fall(sdi_fall)
  );

  sync_edge #(.RST_VAL(1'b1)) u_sync_cs (
    .clk(aclk), .rst(areset), .din(cs_n),
    .level(cs_level), .rise(cs_rise), .fall(cs_fall)
  );

  // Only the sclk rise and the sdi level matter; the other strobes are spare.
  assign unused_edges = ^{sclk_level, sclk_fall, sdi_rise, sdi_fall};

  // The cs_n chain resets to 1, so its level is meaningless until two real
  // pin samples have flushed it; this stops a frame in flight at reset
  // release from looking like an idle line.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) settle_cnt <= 2'd0;
    else if (!settle_cnt[1]) settle_cnt <= settle_cnt + 2'd1;
  end

  assign settled = settle_cnt[1];

  // State register.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) state <= WAIT_IDLE;
    else        state <= state_next;
  end

  // Next-state logic: frame open/close decisions.
  always_comb begin
    state_next  = state;
    clear_frame = 1'b0;
    close_frame = 1'b0;
    case (state)
      WAIT_IDLE: if (settled && cs_level) state_next = IDLE;
      IDLE: if (cs_fall) begin
        clear_frame = 1'b1;
        state_next  = SHIFT;
      end
      SHIFT: if (cs_rise) begin
        close_frame = 1'b1;
        state_next  = IDLE;
      end
      default: state_next = WAIT_IDLE;
    endcase
  end

  // A clock edge coinciding with the closing cs_n edge is folded in before
  // the frame is judged, so evaluation looks at the post-shift values.
  assign shift_take = (state == SHIFT) && sclk_rise;
  assign shift_next = shift_take ? {shift_reg[DW-2:0], sdi_level} : shift_reg;
  assign count_next = (shift_take && bit_cnt != CNT_MAX) ? bit_cnt + CNTW'(1) : bit_cnt;
  assign good_word  = close_frame && (count_next == CNT_FULL);
  assign bad_word   = close_frame && (count_next != CNT_FULL);
  assign ovf_hit    = good_word && m_axis_tvalid && !m_axis_tready;

  // Shift register and bit counter for the frame being received.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else if (clear_frame) begin
      shift_reg <= '0;
      bit_cnt   <= '0;
    end else begin
      shift_reg <= shift_next;
      bit_cnt   <= count_next;
    end
  end

  // Single-entry output register; a newer good word always replaces an
  // unaccepted one.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      m_axis_tvalid <= 1'b0;
      m_axis_tdata  <= '0;
    end else if (good_word) begin
      m_axis_tvalid <= 1'b1;
      m_axis_tdata  <= shift_next;
    end else if (m_axis_tvalid && m_axis_tready) begin
      m_axis_tvalid <= 1'b0;
    end
  end

  // Error strobes and their saturating counters.
  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      frame_err <= 1'b0;
      overflow  <= 1'b0;
      err_cnt   <= '0;
      ovf_cnt   <= '0;
    end else begin
      frame_err <= bad_word;
      overflow  <= ovf_hit;
      if (bad_word && err_cnt != {CW{1'b1}}) err_cnt <= err_cnt + CW'(1);
      if (ovf_hit && ovf_cnt != {CW{1'b1}}) ovf_cnt <= ovf_cnt + CW'(1);
    end
  end

endmodule
